aes_spi_frame_ctrl: RTL and testbench

- Sequences one AES operation per SPI frame.
- Deserialises a mode bit, a 128-bit block and an Nk*32-bit key from SIMO while CSS is low.
- Pulses a start handshake to the shared Cipher/InverseCipher core wrapper, then serialises the 128-bit result on SOMI.
- Sits between the SPI pins and the AES core; replaces free-running integer bit counters with a resettable FSM.

---
 rtl/aes_spi_pkg.sv | 26 ++
 rtl/aes_spi_frame_ctrl_shifter.sv | 33 +++
 rtl/aes_spi_frame_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_aes_spi_frame_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_spi_pkg.sv
// Shared definitions for the AES SPI frame controller.
//   state_e   : frame sequencer states (3-bit encoding, also exposed on dbg_state)
//   ENCR/DECR : values of the mode bit / core_mode
//   BLK_W     : AES block width in bits
//   key_width : key width in bits for a given Nk (32-bit words)
package aes_spi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_DATA = 3'd1,
        RX_KEY  = 3'd2,
        START   = 3'd3,
        WAIT    = 3'd4,
        TX      = 3'd5,
        DONE    = 3'd6
    } state_e;

    localparam logic ENCR  = 1'b0;
    localparam logic DECR  = 1'b1;
    localparam int   BLK_W = 128;

    function automatic int key_width(input int nk);
        return nk * 32;
    endfunction

endpackage

// File: rtl/aes_spi_frame_ctrl_shifter.sv
// spi_lsb_shifter: LSB-first shift register used for the SPI data paths.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears q)
//   load_en       : parallel load of load_val (highest priority)
//   shift_in_en   : q <= {sin, q[W-1:1]}  (serial bits arrive LSB first)
//   shift_out_en  : q <= {1'b0, q[W-1:1]} (q[0] is the next bit to send)
//   q             : register contents
module spi_lsb_shifter #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    input  logic         shift_in_en,
    input  logic         sin,
    input  logic         shift_out_en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load_en) begin
            q <= load_val;
        end else if (shift_in_en) begin
            q <= {sin, q[W-1:1]};
        end else if (shift_out_en) begin
            q <= {1'b0, q[W-1:1]};
        end
    end

endmodule

// File: rtl/aes_spi_frame_ctrl.sv
// aes_spi_frame_ctrl: runs one AES operation per SPI frame.
// A frame is: bit 0 = mode, bits 1..128 = block, then Nk*32 key bits, all LSB
// first on SIMO while CSS is low. The controller then starts the core, waits
// for its result and returns it LSB first on SOMI while CSS is low.
// Optional build macro: AES_SPI_WATCHDOG_EN (WAIT times out after WD_CYCLES).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   CSS, SIMO, SOMI     : SPI chip select (active low), data in, data out
//   busy, err           : frame in progress, sticky abort/timeout flag
//   core_start/core_done: handshake with the AES core wrapper
//   core_mode/data/key  : operation inputs to the core
//   core_result         : core output, valid with core_done
//   dbg_state           : current sequencer state (aes_spi_pkg::state_e)
//
// Core handshake: core_start is a one-cycle request that is always accepted
// by the core; core_mode, core_data and core_key stay stable until the core
// answers with a one-cycle core_done, whose core_result is captured in that
// same cycle. core_done is only honoured in WAIT, which begins the cycle after
// core_start, so a done coincident with start is never taken.
module aes_spi_frame_ctrl
    import aes_spi_pkg::*;
#(
    parameter int Nk        = 4,
    parameter int WD_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    CSS,
    input  logic                    SIMO,
    output logic                    SOMI,
    output logic                    busy,
    output logic                    err,
    output logic                    core_start,
    output logic                    core_mode,
    output logic [BLK_W-1:0]        core_data,
    output logic [key_width(Nk)-1:0] core_key,
    input  logic                    core_done,
    input  logic [BLK_W-1:0]        core_result,
    output logic [2:0]              dbg_state
);

    localparam int KW    = key_width(Nk);
    localparam int CNT_W = $clog2(1 + BLK_W + KW + 1);

    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_RX_DATA = RX_DATA;
    localparam logic [2:0] ST_RX_KEY  = RX_KEY;
    localparam logic [2:0] ST_START   = START;
    localparam logic [2:0] ST_WAIT    = WAIT;
    localparam logic [2:0] ST_TX      = TX;
    localparam logic [2:0] ST_DONE    = DONE;

    logic [2:0]       state;
    // Frame bits consumed so far during RX; result bits sent so far during TX.
    logic [CNT_W-1:0] cnt;
    logic [BLK_W-1:0] tx_q;

    logic data_sh, key_sh, tx_load, tx_sh;

    assign data_sh = (state == ST_RX_DATA) && !CSS;
    assign key_sh  = (state == ST_RX_KEY)  && !CSS;
    assign tx_load = (state == ST_WAIT)    && core_done;
    assign tx_sh   = (state == ST_TX)      && !CSS;

    assign busy       = (state != ST_IDLE);
    assign core_start = (state == ST_START);
    assign dbg_state  = state;

    spi_lsb_shifter #(.W(BLK_W)) u_data_sh (
        .clk(clk), .rst(rst), .load_en(1'b0), .load_val('0),
        .shift_in_en(data_sh), .sin(SIMO), .shift_out_en(1'b0), .q(core_data)
    );

    spi_lsb_shifter #(.W(KW)) u_key_sh (
        .clk(clk), .rst(rst), .load_en(1'b0), .load_val('0),
        .shift_in_en(key_sh), .sin(SIMO), .shift_out_en(1'b0), .q(core_key)
    );

    spi_lsb_shifter #(.W(BLK_W)) u_tx_sh (
        .clk(clk), .rst(rst), .load_en(tx_load), .load_val(core_result),
        .shift_in_en(1'b0), .sin(1'b0), .shift_out_en(tx_sh), .q(tx_q)
    );

    // Only the LSB of the tx register is ever sent.
    logic unused_tx;
    assign unused_tx = &tx_q[BLK_W-1:1];

`ifdef AES_SPI_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;

    assign wd_expire = (wd_cnt == WD_W'(WD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || state != ST_WAIT) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end
`else
    logic unused_wd;
    assign unused_wd = (WD_CYCLES > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            core_mode <= ENCR;
            err       <= 1'b0;
            SOMI      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!CSS) begin
                        core_mode <= SIMO;
                        err       <= 1'b0;
                        cnt       <= CNT_W'(1);
                        state     <= ST_RX_DATA;
                    end
                end
                ST_RX_DATA: begin
                    if (CSS) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        // cnt == k while the k-th data bit is sampled
                        if (cnt == CNT_W'(BLK_W)) state <= ST_RX_KEY;
                    end
                end
                ST_RX_KEY: begin
                    if (CSS) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(BLK_W + KW)) state <= ST_START;
                    end
                end
                ST_START: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done) begin
                        cnt   <= '0;
                        state <= ST_TX;
                    end
`ifdef AES_SPI_WATCHDOG_EN
                    else if (wd_expire) begin
                        err   <= 1'b1;
                        SOMI  <= 1'b0;
                        state <= ST_DONE;
                    end
`endif
                end
                ST_TX: begin
                    // CSS high stalls the shift and holds SOMI
                    if (!CSS) begin
                        SOMI <= tx_q[0];
                        cnt  <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(BLK_W - 1)) state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    SOMI <= 1'b0;
                    if (CSS) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_spi_frame_ctrl.sv
`timescale 1ns/1ps
module tb_aes_spi_frame_ctrl;

    localparam int NK    = 4;
    localparam int KW    = NK * 32;
    localparam int FRAME = 1 + 128 + KW;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [KW-1:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;

    logic clk = 1'b0;
    logic rst, css, simo, somi, busy, err, core_start, core_mode, core_done;
    logic [127:0]  core_data, core_result;
    logic [KW-1:0] core_key;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    // Scoreboard: result blocks expected back on SOMI, oldest first.
    logic [127:0] exp_q[$];
    // Reference model of the registers the DUT exposes to the core.
    logic [127:0]  model_data;
    logic [KW-1:0] model_key;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    aes_spi_frame_ctrl #(.Nk(NK), .WD_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .CSS(css), .SIMO(simo), .SOMI(somi),
        .busy(busy), .err(err), .core_start(core_start), .core_mode(core_mode),
        .core_data(core_data), .core_key(core_key), .core_done(core_done),
        .core_result(core_result), .dbg_state(dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver tasks ----------------
    // Send the first nbits of the frame {key, data, mode}, LSB first.
    // starts counts core_start pulses seen before the last bit's edge.
    task automatic drive_rx(input logic m, input logic [127:0] d, input logic [KW-1:0] k,
                            input int nbits, output int starts);
        logic [FRAME-1:0] bits;
        bits   = {k, d, m};
        starts = 0;
        for (int i = 0; i < nbits; i++) begin
            css  = 1'b0;
            simo = bits[i];
            tick();
            if (i < nbits - 1 && core_start === 1'b1) starts++;
        end
    endtask

    // Called with the DUT in its start cycle; plays the core with latency lat.
    task automatic core_wait(input logic m, input int lat, input logic [127:0] res,
                             output int mode_bad, output int extra_starts);
        mode_bad     = 0;
        extra_starts = 0;
        for (int c = 0; c < lat; c++) begin
            css  = 1'($urandom_range(0, 1));
            simo = 1'($urandom_range(0, 1));
            tick();
            if (core_mode !== m) mode_bad++;
            if (core_start !== 1'b0) extra_starts++;
        end
        core_done   = 1'b1;
        core_result = res;
        tick();
        core_done   = 1'b0;
        core_result = rand128();
    endtask

    task automatic drive_tx(input int nbits, input int stall_at, input int stall_len,
                            output logic [127:0] got, output int hold_bad);
        got      = '0;
        hold_bad = 0;
        for (int i = 0; i < nbits; i++) begin
            if (i == stall_at && i > 0) begin
                for (int s = 0; s < stall_len; s++) begin
                    css = 1'b1;
                    tick();
                    if (somi !== got[i-1]) hold_bad++;
                end
            end
            css = 1'b0;
            tick();
            got[i] = somi;
        end
    endtask

    task automatic end_frame();
        css = 1'b1;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; css = 1'b0; simo = 1'b1;
        tick(); tick();
        checks++;
        if (somi !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || core_start !== 1'b0 || core_mode !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: somi=%b busy=%b err=%b start=%b mode=%b, required all 0",
                     somi, busy, err, core_start, core_mode);
        end
        checks++;
        if (core_data !== '0 || core_key !== '0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_regs: data=%h key=%h state=%0d, required 0/0/IDLE",
                     core_data, core_key, dbg_state);
        end
        rst = 1'b0;
        end_frame();
        model_data = '0;
        model_key  = '0;
    endtask

    // One complete frame with full checking.
    task automatic test_full_frame(input string tag, input logic m, input logic [127:0] d,
                                   input logic [KW-1:0] k, input logic [127:0] r,
                                   input int lat, input int stall_at, input int stall_len);
        int starts, mode_bad, extra, hold_bad;
        logic [127:0] got, exp;
        drive_rx(m, d, k, FRAME, starts);
        model_data = d;
        model_key  = k;
        checks++;
        if (core_start !== 1'b1 || starts != 0) begin
            errors++;
            $display("FAIL %s start_pulse: core_start=%b early=%0d, required 1 and 0", tag, core_start, starts);
        end
        checks++;
        if (core_data !== model_data) begin
            errors++;
            $display("FAIL %s core_data: got %h, required %h", tag, core_data, model_data);
        end
        checks++;
        if (core_key !== model_key) begin
            errors++;
            $display("FAIL %s core_key: got %h, required %h", tag, core_key, model_key);
        end
        checks++;
        if (core_mode !== m || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s mode_busy: mode=%b busy=%b, required %b and 1", tag, core_mode, busy, m);
        end
        exp_q.push_back(r);
        core_wait(m, lat, r, mode_bad, extra);
        checks++;
        if (mode_bad != 0 || extra != 0) begin
            errors++;
            $display("FAIL %s wait_phase: mode_changes=%0d extra_starts=%0d, required 0 and 0", tag, mode_bad, extra);
        end
        drive_tx(128, stall_at, stall_len, got, hold_bad);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s somi_stream: got %h, required %h", tag, got, exp);
        end
        checks++;
        if (hold_bad != 0) begin
            errors++;
            $display("FAIL %s stall_hold: %0d stalled cycles changed SOMI, required 0", tag, hold_bad);
        end
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s before_css_rise: busy=%b err=%b, required 1 and 0", tag, busy, err);
        end
        end_frame();
        checks++;
        if (busy !== 1'b0 || somi !== 1'b0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL %s after_css_rise: busy=%b somi=%b state=%0d, required 0/0/IDLE",
                     tag, busy, somi, dbg_state);
        end
    endtask

    task automatic test_encrypt();
        test_full_frame("encrypt", 1'b0, PT, KEY, CT, 11, -1, 0);
    endtask

    task automatic test_decrypt();
        test_full_frame("decrypt", 1'b1, CT, KEY, PT, 11, -1, 0);
    endtask

    task automatic test_abort();
        int starts;
        logic [127:0]  d;
        logic [KW-1:0] k;
        // abort after 50 data bits
        d = rand128();
        k = KW'(rand128());
        drive_rx(1'b0, d, k, 51, starts);
        end_frame();
        model_data = (model_data >> 50) | (d << 78);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || core_start !== 1'b0 || starts != 0) begin
            errors++;
            $display("FAIL abort_data: err=%b busy=%b start=%b starts=%0d, required 1/0/0/0",
                     err, busy, core_start, starts);
        end
        checks++;
        if (core_data !== model_data || core_key !== model_key) begin
            errors++;
            $display("FAIL abort_partial: data=%h key=%h, required %h %h", core_data, core_key, model_data, model_key);
        end
        // abort after 40 key bits
        drive_rx(1'b1, d, k, 1 + 128 + 40, starts);
        end_frame();
        model_data = d;
        model_key  = (model_key >> 40) | (k << (KW - 40));
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || starts != 0 || core_key !== model_key || core_data !== model_data) begin
            errors++;
            $display("FAIL abort_key: err=%b busy=%b starts=%0d key=%h, required 1/0/0 key %h",
                     err, busy, starts, core_key, model_key);
        end
        test_full_frame("after_abort", 1'b0, rand128(), KW'(rand128()), rand128(), 5, -1, 0);
    endtask

    task automatic test_reset_mid_tx();
        int starts, mode_bad, extra, hold_bad;
        logic [127:0] d, r, got;
        d = rand128();
        r = rand128();
        drive_rx(1'b0, d, KEY, FRAME, starts);
        core_wait(1'b0, 3, r, mode_bad, extra);
        drive_tx(20, -1, 0, got, hold_bad);
        checks++;
        if (got[19:0] !== r[19:0]) begin
            errors++;
            $display("FAIL rst_tx_prefix: got %h, required %h", got[19:0], r[19:0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (somi !== 1'b0 || busy !== 1'b0 || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL rst_mid_tx: somi=%b busy=%b state=%0d, required 0/0/IDLE", somi, busy, dbg_state);
        end
        model_data = '0;
        model_key  = '0;
        end_frame();
        checks++;
        if (somi !== 1'b0 || core_data !== model_data) begin
            errors++;
            $display("FAIL rst_quiet: somi=%b data=%h, required 0 and 0", somi, core_data);
        end
        test_full_frame("after_reset", 1'b1, rand128(), KW'(rand128()), rand128(), 7, -1, 0);
    endtask

    task automatic test_tx_stall();
        test_full_frame("tx_stall", 1'b0, rand128(), KW'(rand128()), rand128(), 4, 60, 5);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            int stall;
            stall = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 127)) : -1;
            test_full_frame("random", 1'($urandom_range(0, 1)), rand128(), KW'(rand128()),
                            rand128(), int'($urandom_range(1, 20)), stall, int'($urandom_range(1, 6)));
        end
    endtask

`ifdef AES_SPI_WATCHDOG_EN
    task automatic test_watchdog();
        int starts, early;
        logic [127:0] d;
        d = rand128();
        drive_rx(1'b0, d, KEY, FRAME, starts);
        model_data = d;
        model_key  = KEY;
        css = 1'b0;
        tick();  // now in WAIT
        early = 0;
        for (int c = 1; c < 64; c++) begin
            tick();
            if (err !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL wd_early: err high in %0d cycles before expiry, required 0", early);
        end
        tick();
        checks++;
        if (err !== 1'b1 || dbg_state !== S_DONE || somi !== 1'b0) begin
            errors++;
            $display("FAIL wd_expire: err=%b state=%0d somi=%b, required 1/DONE/0", err, dbg_state, somi);
        end
        tick(); tick();
        checks++;
        if (somi !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wd_hold: somi=%b busy=%b, required 0 and 1", somi, busy);
        end
        end_frame();
        checks++;
        if (busy !== 1'b0 || dbg_state !== S_IDLE || err !== 1'b1) begin
            errors++;
            $display("FAIL wd_idle: busy=%b state=%0d err=%b, required 0/IDLE/1", busy, dbg_state, err);
        end
        test_full_frame("after_wd", 1'b0, rand128(), KW'(rand128()), rand128(), 9, -1, 0);
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1; css = 1'b1; simo = 1'b0; core_done = 1'b0; core_result = '0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_abort();
        test_reset_mid_tx();
        test_tx_stall();
        test_back_to_back();
`ifdef AES_SPI_WATCHDOG_EN
        test_watchdog();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
